// File: rtl/shift_left_seq_if.sv
// rtl/shift_left_seq_if.sv - start/ready handshake bundle for the sequential left shifter
interface shift_left_seq_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   result;
    logic               ovf;
    logic               busy;
    logic               result_ready;

    modport master (
        output start, data_in, shamt,
        input  result, ovf, busy, result_ready
    );

    modport slave (
        input  start, data_in, shamt,
        output result, ovf, busy, result_ready
    );
endinterface

// File: rtl/shift_left_seq.sv
// rtl/shift_left_seq.sv - five-cycle 32-bit left shifter with signed overflow detect
module shift_left_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic            clock,
    input logic            reset,
    shift_left_seq_if.slave bus
);
    localparam int CNT_W = $clog2(SHAMT_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_shamt;
    logic [CNT_W-1:0]   r_stage;
    logic               r_sign;
    logic               r_ovf_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic [CNT_W-1:0]   w_bit;
    logic               w_ctrl;
    logic [SHAMT_W-1:0] w_dist;
    logic [WIDTH-1:0]   w_mask;
    logic               w_viol;
    logic [WIDTH-1:0]   w_work_next;
    logic               w_acc_next;

    // Stage k uses distance WIDTH/2 >> k, controlled by shamt bit (SHAMT_W-1-k).
    assign w_accept = bus.start && (r_state != SHIFT);
    assign w_last   = (r_stage == CNT_W'(SHAMT_W - 1));
    assign w_bit    = CNT_W'(SHAMT_W - 1) - r_stage;
    assign w_ctrl   = r_shamt[w_bit];
    assign w_dist   = SHAMT_W'(WIDTH / 2) >> r_stage;

    // The top dist bits leave the word and bit dist below them becomes the new MSB;
    // all of those must match the original sign for the signed value to survive.
    assign w_mask      = ~({WIDTH{1'b1}} >> (w_dist + SHAMT_W'(1)));
    assign w_viol      = |((r_work ^ {WIDTH{r_sign}}) & w_mask);
    assign w_work_next = w_ctrl ? (r_work << w_dist) : r_work;
    assign w_acc_next  = r_ovf_acc | (w_ctrl & w_viol);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection and status outputs decoded from the current state.
    always_comb begin
        w_state_next     = r_state;
        bus.busy         = 1'b0;
        bus.result_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_state_next = SHIFT;
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                bus.result_ready = 1'b1;
                w_state_next     = bus.start ? SHIFT : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, one shift stage per cycle, and result/flag commit on the last stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_work    <= '0;
            r_shamt   <= '0;
            r_stage   <= '0;
            r_sign    <= 1'b0;
            r_ovf_acc <= 1'b0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_work    <= bus.data_in;
            r_shamt   <= bus.shamt;
            r_stage   <= '0;
            r_sign    <= bus.data_in[WIDTH-1];
            r_ovf_acc <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_work    <= w_work_next;
            r_ovf_acc <= w_acc_next;
            r_stage   <= r_stage + CNT_W'(1);
            if (w_last) begin
                r_result <= w_work_next;
                r_ovf    <= w_acc_next;
            end
        end
    end

    assign bus.result = r_result;
    assign bus.ovf    = r_ovf;
endmodule
